// File: rtl/s13207_seq_pkg.sv
// Shared types and constants for the s13207 read-select sequencer.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package s13207_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DONE   = 2'd2
  } seq_state_e;

  // Enable pattern {g41,g42,g44,g45,g55} that routes the select code into the datapath.
  localparam logic [4:0] SEL_EN_ACTIVE = 5'b00100;
  localparam logic [4:0] SEL_EN_OFF    = 5'b00000;

  // Upper nibble of a select code drives {g80,g83,g52,g86}.
  function automatic logic [3:0] code_bank(input logic [7:0] code);
    return code[7:4];
  endfunction

  // Lower nibble of a select code drives {g68,g71,g74,g77}.
  function automatic logic [3:0] code_op(input logic [7:0] code);
    return code[3:0];
  endfunction

endpackage

// File: rtl/s13207_rr_arb2.sv
// Two-way round-robin arbiter; prio_q names the requester that wins a tie.
// Latency: combinational grant decision; priority updates one edge after upd_i.
// Backpressure: none; the caller strobes upd_i only when a grant is retired.
module s13207_rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  input  logic       upd_idx_i,
  output logic       vld_o,
  output logic       idx_o
);

  logic prio_q, prio_d;

  // After serving a requester, the other one wins the next tie.
  always_comb begin
    prio_d = prio_q;
    if (upd_i) prio_d = ~upd_idx_i;
  end

  // Tie-break pointer; requester 0 is favoured out of reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) prio_q <= 1'b0;
    else       prio_q <= prio_d;
  end

  // A lone requester always wins; a tie goes to prio_q.
  always_comb begin
    vld_o = |req_i;
    idx_o = (req_i == 2'b11) ? prio_q : ~req_i[0];
  end

endmodule

// File: rtl/s13207_rd_sequencer.sv
// Arbitrates two burst requesters, steps select codes into the s13207 datapath, packs g9299 samples.
// Latency: rd_valid rises len*(SETTLE+1) cycles after the grant edge.
// Backpressure: result held in DONE until rd_ready; no new grant until then. Option: SEQ_PARITY_EN adds rd_par.
module s13207_rd_sequencer
  import s13207_seq_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int SETTLE = 2
) (
  input  logic              CK,
  input  logic              RST,
  input  logic              req0,
  input  logic [7:0]        base0,
  input  logic [4:0]        len0,
  input  logic              req1,
  input  logic [7:0]        base1,
  input  logic [4:0]        len1,
  output logic [1:0]        gnt,
  output logic [3:0]        sel_op,
  output logic [3:0]        sel_bank,
  output logic [4:0]        sel_en,
  input  logic              mux_q,
  output logic              rd_valid,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_id,
  input  logic              rd_ready,
  output logic              busy
`ifdef SEQ_PARITY_EN
  ,
  output logic              rd_par
`endif
);

  localparam logic [4:0] WLEN = 5'(WORD_W);
  localparam logic [3:0] HOLD = 4'(SETTLE);

  seq_state_e        state_q, state_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [7:0]        code_q, code_d;
  logic [4:0]        idx_q, idx_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [4:0]        len_q, len_d;
  logic [4:0]        sel_en_q, sel_en_d;
  logic              rd_valid_q, rd_valid_d;
  logic [WORD_W-1:0] rd_data_q, rd_data_d;
  logic              rd_id_q, rd_id_d;

  logic              arb_vld, arb_idx, arb_upd;
  logic [4:0]        len_sel, len_eff;
  logic [7:0]        base_sel;

  s13207_rr_arb2 u_arb (
    .clk_i     (CK),
    .rst_i     (RST),
    .req_i     ({req1, req0}),
    .upd_i     (arb_upd),
    .upd_idx_i (gnt_q[1]),
    .vld_o     (arb_vld),
    .idx_o     (arb_idx)
  );

  // Winner's burst parameters; zero or oversize lengths collapse to a full word.
  always_comb begin
    len_sel  = arb_idx ? len1 : len0;
    base_sel = arb_idx ? base1 : base0;
    len_eff  = ((len_sel == 5'd0) || (len_sel > WLEN)) ? WLEN : len_sel;
  end

  // Next-state and datapath control: grant in IDLE, hold/sample in SETTLE, present in DONE.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    code_d     = code_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    sel_en_d   = sel_en_q;
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    rd_id_d    = rd_id_q;
    arb_upd    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_vld) begin
          gnt_d     = arb_idx ? 2'b10 : 2'b01;
          code_d    = base_sel;
          idx_d     = 5'd0;
          cnt_d     = HOLD;
          len_d     = len_eff;
          rd_data_d = '0;
          sel_en_d  = SEL_EN_ACTIVE;
          state_d   = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == 4'd0) begin
          // Result bits are cleared at grant, so OR-ing in one bit per code is enough.
          rd_data_d = rd_data_q | (WORD_W'(mux_q) << idx_q);
          if (idx_q == len_q - 5'd1) begin
            sel_en_d   = SEL_EN_OFF;
            rd_valid_d = 1'b1;
            rd_id_d    = gnt_q[1];
            state_d    = ST_DONE;
          end else begin
            code_d = code_q + 8'd1;
            idx_d  = idx_q + 5'd1;
            cnt_d  = HOLD;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: begin
        if (rd_valid_q && rd_ready) begin
          rd_valid_d = 1'b0;
          gnt_d      = 2'b00;
          arb_upd    = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any burst in flight.
  always_ff @(posedge CK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      gnt_q      <= 2'b00;
      code_q     <= 8'd0;
      idx_q      <= 5'd0;
      cnt_q      <= 4'd0;
      len_q      <= 5'd0;
      sel_en_q   <= SEL_EN_OFF;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_id_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      code_q     <= code_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      sel_en_q   <= sel_en_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_id_q    <= rd_id_d;
    end
  end

`ifdef SEQ_PARITY_EN
  logic rd_par_q;

  // Parity tracks rd_data in the same register stage.
  always_ff @(posedge CK) begin
    if (RST) rd_par_q <= 1'b0;
    else     rd_par_q <= ^rd_data_d;
  end

  assign rd_par = rd_par_q;
`endif

  assign gnt      = gnt_q;
  assign sel_op   = code_op(code_q);
  assign sel_bank = code_bank(code_q);
  assign sel_en   = sel_en_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_id    = rd_id_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_s13207_rd_sequencer.sv
// Directed bench for s13207_rd_sequencer; datapath modelled as g9299 = code[0].
// Latency: expected rd_valid delay is len*(SETTLE+1) with SETTLE=2.
// Backpressure: rd_ready driven by the bench to hold results in DONE.
module tb_s13207_rd_sequencer;

  logic       CK = 1'b0;
  logic       RST;
  logic       req0, req1;
  logic [7:0] base0, base1;
  logic [4:0] len0, len1;
  logic [1:0] gnt;
  logic [3:0] sel_op, sel_bank;
  logic [4:0] sel_en;
  logic       mux_q;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       rd_id;
  logic       rd_ready;
  logic       busy;
`ifdef SEQ_PARITY_EN
  logic       rd_par;
`endif

  logic [7:0] code;
  logic [7:0] codes[$];
  int         n_tests = 0;
  int         n_fail  = 0;

  always #5 CK = ~CK;

  assign code  = {sel_bank, sel_op};
  assign mux_q = sel_op[0];

  s13207_rd_sequencer #(.WORD_W(8), .SETTLE(2)) dut (
    .CK       (CK),
    .RST      (RST),
    .req0     (req0),
    .base0    (base0),
    .len0     (len0),
    .req1     (req1),
    .base1    (base1),
    .len1     (len1),
    .gnt      (gnt),
    .sel_op   (sel_op),
    .sel_bank (sel_bank),
    .sel_en   (sel_en),
    .mux_q    (mux_q),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .rd_id    (rd_id),
    .rd_ready (rd_ready),
    .busy     (busy)
`ifdef SEQ_PARITY_EN
    ,
    .rd_par   (rd_par)
`endif
  );

  task automatic tick();
    @(negedge CK);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Requests must already be set up; one tick later the grant edge has passed.
  task automatic run_burst(input string tag, input logic [1:0] egnt, input int elat,
                           input logic [7:0] edata, input logic eid);
    int k;
    codes.delete();
    tick();
    check({tag, " gnt"}, gnt, egnt);
    check({tag, " busy"}, busy, 1);
    check({tag, " sel_en"}, sel_en, 5'b00100);
    codes.push_back(code);
    k = 0;
    while (!rd_valid && k < 200) begin
      tick();
      k++;
      if (sel_en == 5'b00100 && code != codes[codes.size()-1]) codes.push_back(code);
    end
    check({tag, " latency"}, k, elat);
    check({tag, " rd_data"}, rd_data, edata);
    check({tag, " rd_id"}, rd_id, eid);
    check({tag, " sel_en off"}, sel_en, 5'b00000);
  endtask

  task automatic accept(input string tag);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    check({tag, " valid clr"}, rd_valid, 0);
    check({tag, " gnt clr"}, gnt, 0);
    check({tag, " idle"}, busy, 0);
  endtask

  initial begin
    RST = 1'b1; rd_ready = 1'b0;
    req0 = 1'b0; base0 = 8'h00; len0 = 5'd0;
    req1 = 1'b0; base1 = 8'h00; len1 = 5'd0;
    repeat (2) tick();
    check("rst gnt", gnt, 0);
    check("rst sel_op", sel_op, 0);
    check("rst sel_bank", sel_bank, 0);
    check("rst sel_en", sel_en, 0);
    check("rst rd_valid", rd_valid, 0);
    check("rst rd_data", rd_data, 0);
    check("rst rd_id", rd_id, 0);
    check("rst busy", busy, 0);
    RST = 1'b0;

    // Codes 15,16,17 -> bits 1,0,1.
    req0 = 1'b1; base0 = 8'h15; len0 = 5'd3;
    run_burst("single", 2'b01, 9, 8'h05, 1'b0);
    check("single ncodes", codes.size(), 3);
    if (codes.size() == 3) begin
      check("single code0", codes[0], 8'h15);
      check("single code1", codes[1], 8'h16);
      check("single code2", codes[2], 8'h17);
    end
    accept("single");
    req0 = 1'b0;

    // Reset in the middle of a burst.
    req0 = 1'b1; base0 = 8'h20; len0 = 5'd4;
    tick();
    check("midrst gnt", gnt, 2'b01);
    repeat (3) tick();
    check("midrst busy", busy, 1);
    RST = 1'b1;
    repeat (2) tick();
    check("midrst gnt0", gnt, 0);
    check("midrst sel_en0", sel_en, 0);
    check("midrst valid0", rd_valid, 0);
    check("midrst data0", rd_data, 0);
    check("midrst busy0", busy, 0);
    RST = 1'b0; req0 = 1'b0;

    // Recovery with requester 1, code wrapping FE,FF,00,01 -> bits 0,1,0,1.
    req1 = 1'b1; base1 = 8'hFE; len1 = 5'd4;
    run_burst("wrap", 2'b10, 12, 8'h0A, 1'b1);
    check("wrap ncodes", codes.size(), 4);
    if (codes.size() == 4) begin
      check("wrap code0", codes[0], 8'hFE);
      check("wrap code1", codes[1], 8'hFF);
      check("wrap code2", codes[2], 8'h00);
      check("wrap code3", codes[3], 8'h01);
    end
    accept("wrap");
    req1 = 1'b0;

    // Both requesters held: grants alternate.
    req0 = 1'b1; base0 = 8'h01; len0 = 5'd1;
    req1 = 1'b1; base1 = 8'h02; len1 = 5'd1;
    run_burst("cont1", 2'b01, 3, 8'h01, 1'b0);
    accept("cont1");
    run_burst("cont2", 2'b10, 3, 8'h00, 1'b1);
    accept("cont2");
    run_burst("cont3", 2'b01, 3, 8'h01, 1'b0);
    accept("cont3");

    // Pointer now favours requester 1; reset must restore requester 0 priority.
    RST = 1'b1;
    tick();
    RST = 1'b0;
    run_burst("ptr_rst", 2'b01, 3, 8'h01, 1'b0);
    accept("ptr_rst");
    req0 = 1'b0; req1 = 1'b0;
    tick();

    // len0=0 -> 8 codes 00..07 -> 0xAA; then hold under backpressure.
    req0 = 1'b1; base0 = 8'h00; len0 = 5'd0;
    run_burst("len0", 2'b01, 24, 8'hAA, 1'b0);
    req1 = 1'b1; base1 = 8'h03; len1 = 5'd20;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp valid", rd_valid, 1);
      check("bp data", rd_data, 8'hAA);
      check("bp gnt", gnt, 2'b01);
    end
    accept("len0");
    req0 = 1'b0;

    // len1=20 -> 8 codes 03..0A -> 0x55.
    run_burst("len20", 2'b10, 24, 8'h55, 1'b1);
    accept("len20");
    req1 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
